// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_W data bits LSB first, optional parity, stop.
// Optional macro UART_TX_TWO_STOP_EN selects two stop bits.
module uart_tx_frame #(
    parameter int DATA_W  = 8,
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               par_en,
    input  logic               par_typ,
    input  logic [DATA_W-1:0]  data_in,
    input  logic               data_valid,
    output logic               busy,
    output logic               tx_out
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
    localparam logic [PRESC_W-1:0] P_ONE = PRESC_W'(1);
    localparam logic [PRESC_W-1:0] P_TWO = PRESC_W'(2);

`ifdef UART_TX_TWO_STOP_EN
    localparam logic TWO_STOP = 1'b1;
`else
    localparam logic TWO_STOP = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t             state_q, state_d;
    logic [PRESC_W-1:0] cnt_q, cnt_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               par_en_q, par_en_d;
    logic               par_typ_q, par_typ_d;
    logic               stop2_q, stop2_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;

    logic               accept;
    logic               bit_last;
    logic               start_frame;
    logic [PRESC_W-1:0] presc_in;

    assign busy   = busy_q;
    assign tx_out = tx_q;

    // Next-state, counters and registered outputs derived from the next state
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        presc_d     = presc_q;
        idx_d       = idx_q;
        data_d      = data_q;
        par_en_d    = par_en_q;
        par_typ_d   = par_typ_q;
        stop2_d     = stop2_q;
        tx_d        = 1'b1;
        busy_d      = 1'b0;
        start_frame = 1'b0;

        accept   = data_valid && !busy_q;
        bit_last = (cnt_q == presc_q - P_ONE);
        presc_in = (prescale < P_TWO) ? P_TWO : prescale;

        unique case (state_q)
            S_IDLE: begin
                if (accept) start_frame = 1'b1;
            end
            S_START: begin
                if (bit_last) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + P_ONE;
                end
            end
            S_DATA: begin
                if (bit_last) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + P_ONE;
                end
            end
            S_PARITY: begin
                if (bit_last) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + P_ONE;
                end
            end
            S_STOP: begin
                if (bit_last) begin
                    if (TWO_STOP && !stop2_q) begin
                        stop2_d = 1'b1;
                        cnt_d   = '0;
                    end else if (accept) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        stop2_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + P_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start_frame) begin
            state_d   = S_START;
            cnt_d     = '0;
            idx_d     = '0;
            stop2_d   = 1'b0;
            data_d    = data_in;
            par_en_d  = par_en;
            par_typ_d = par_typ;
            presc_d   = presc_in;
        end

        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = data_d[idx_d];
            S_PARITY: tx_d = (^data_d) ^ par_typ_d;
            default:  tx_d = 1'b1;
        endcase

        busy_d = (state_d != S_IDLE) &&
                 !(state_d == S_STOP &&
                   cnt_d == presc_d - P_ONE &&
                   (stop2_d || !TWO_STOP));
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            presc_q   <= P_TWO;
            idx_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame: random and directed frames against a
// bit-list reference model of the serial waveform.
module tb_uart_tx_frame;

    logic       clk;
    logic       rst;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic [7:0] data_in;
    logic       data_valid;
    logic       busy;
    logic       tx_out;

    int total;
    int bad;

`ifdef UART_TX_TWO_STOP_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif

    logic obs_tx[$];
    logic obs_busy[$];
    logic exp_tx[$];
    logic exp_busy[$];
    int   exp_len;
    int   first_bad;

    uart_tx_frame #(.DATA_W(8), .PRESC_W(6)) dut (
        .clk(clk),
        .rst(rst),
        .prescale(prescale),
        .par_en(par_en),
        .par_typ(par_typ),
        .data_in(data_in),
        .data_valid(data_valid),
        .busy(busy),
        .tx_out(tx_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line level for each cycle after acceptance, plus one idle cycle
    task automatic build_model(input logic [7:0] d, input logic pe,
                               input logic pt, input int p);
        int pp;
        logic bits[$];
        pp = (p < 2) ? 2 : p;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pe) bits.push_back((^d) ^ pt);
        for (int i = 0; i < NSTOP; i++) bits.push_back(1'b1);
        exp_tx.delete();
        exp_busy.delete();
        foreach (bits[b])
            for (int c = 0; c < pp; c++) exp_tx.push_back(bits[b]);
        exp_len = exp_tx.size();
        for (int k = 0; k < exp_len; k++)
            exp_busy.push_back(k < exp_len - 1);
        exp_tx.push_back(1'b1);
        exp_busy.push_back(1'b0);
    endtask

    task automatic capture(input int n);
        obs_tx.delete();
        obs_busy.delete();
        for (int k = 0; k < n; k++) begin
            obs_tx.push_back(tx_out);
            obs_busy.push_back(busy);
            tick();
        end
    endtask

    function automatic int diff_count();
        int n;
        int e;
        e = 0;
        first_bad = -1;
        n = (obs_tx.size() < exp_tx.size()) ? obs_tx.size() : exp_tx.size();
        for (int k = 0; k < n; k++)
            if (obs_tx[k] !== exp_tx[k] || obs_busy[k] !== exp_busy[k]) begin
                if (first_bad < 0) first_bad = k;
                e++;
            end
        return e;
    endfunction

    function automatic int busy_high();
        int c;
        c = 0;
        foreach (obs_busy[k]) if (obs_busy[k] === 1'b1) c++;
        return c;
    endfunction

    task automatic start_frame(input logic [7:0] d, input logic pe,
                               input logic pt, input logic [5:0] p);
        data_in    = d;
        par_en     = pe;
        par_typ    = pt;
        prescale   = p;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
    endtask

    task automatic test_reset();
        int e;
        rst = 1'b1;
        tick();
        tick();
        total++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: tx_out=%b busy=%b, want tx_out=1 busy=0",
                     tx_out, busy);
        end
        rst = 1'b0;
        tick();
        start_frame(8'h3C, 1'b0, 1'b0, 6'd8);
        capture(30);
        rst = 1'b1;
        #1;
        total++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_frame: tx_out=%b busy=%b, want 1/0",
                     tx_out, busy);
        end
        #2;
        rst = 1'b0;
        tick();
        start_frame(8'h00, 1'b0, 1'b0, 6'd8);
        total++;
        if (tx_out !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_next_start: tx_out=%b busy=%b, want 0/1",
                     tx_out, busy);
        end
        build_model(8'h00, 1'b0, 1'b0, 8);
        capture(exp_len + 1);
        e = diff_count();
        total++;
        if (e !== 0) begin
            bad++;
            $display("FAIL reset_next_frame: %0d bad cycles (first %0d), want 0",
                     e, first_bad);
        end
    endtask

    task automatic test_basic();
        int pat[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        int e;
        int bb;
        start_frame(8'hA5, 1'b0, 1'b0, 6'd8);
        build_model(8'hA5, 1'b0, 1'b0, 8);
        capture(exp_len + 1);
        e = 0;
        for (int b = 0; b < 10; b++)
            for (int c = 0; c < 8; c++)
                if (obs_tx[b*8+c] !== pat[b][0]) e++;
        total++;
        if (e !== 0) begin
            bad++;
            $display("FAIL basic_bits: %0d cycles off pattern, want 0", e);
        end
        bb = busy_high() + 1;
        total++;
        if (bb !== 80 + 8 * (NSTOP - 1)) begin
            bad++;
            $display("FAIL basic_busy: busy=%0d cycles, want %0d",
                     bb, 80 + 8 * (NSTOP - 1));
        end
        e = diff_count();
        total++;
        if (e !== 0) begin
            bad++;
            $display("FAIL basic_model: %0d bad cycles (first %0d), want 0",
                     e, first_bad);
        end
    endtask

    task automatic test_parity();
        logic [7:0] dv[4] = '{8'hA5, 8'hA5, 8'h07, 8'h07};
        logic       tv[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic       pv[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int e;
        int bb;
        for (int i = 0; i < 4; i++) begin
            start_frame(dv[i], 1'b1, tv[i], 6'd16);
            build_model(dv[i], 1'b1, tv[i], 16);
            capture(exp_len + 1);
            total++;
            if (obs_tx[9*16+8] !== pv[i]) begin
                bad++;
                $display("FAIL parity_bit[%0d]: got %b, want %b",
                         i, obs_tx[9*16+8], pv[i]);
            end
            bb = busy_high() + 1;
            total++;
            if (bb !== 176 + 16 * (NSTOP - 1)) begin
                bad++;
                $display("FAIL parity_len[%0d]: got %0d, want %0d",
                         i, bb, 176 + 16 * (NSTOP - 1));
            end
            e = diff_count();
            total++;
            if (e !== 0) begin
                bad++;
                $display("FAIL parity_model[%0d]: %0d bad cycles (first %0d)",
                         i, e, first_bad);
            end
        end
    endtask

    task automatic test_handshake();
        int e;
        int idle_bad;
        build_model(8'h11, 1'b0, 1'b0, 8);
        data_in    = 8'h11;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        prescale   = 6'd8;
        data_valid = 1'b1;
        tick();
        data_in = 8'h22;
        obs_tx.delete();
        obs_busy.delete();
        for (int k = 0; k < exp_len; k++) begin
            obs_tx.push_back(tx_out);
            obs_busy.push_back(busy);
            if (k == 40) begin
                data_in  = 8'hFF;
                par_en   = 1'b1;
                prescale = 6'd16;
            end
            if (k == exp_len - 2) data_valid = 1'b0;
            tick();
        end
        par_en   = 1'b0;
        prescale = 6'd8;
        e = diff_count();
        total++;
        if (e !== 0) begin
            bad++;
            $display("FAIL handshake_frame: %0d bad cycles (first %0d)",
                     e, first_bad);
        end
        idle_bad = 0;
        for (int k = 0; k < 12; k++) begin
            if (tx_out !== 1'b1 || busy !== 1'b0) idle_bad++;
            tick();
        end
        total++;
        if (idle_bad !== 0) begin
            bad++;
            $display("FAIL handshake_no_queue: %0d non-idle cycles, want 0",
                     idle_bad);
        end
    endtask

    task automatic test_back_to_back();
        int e;
        start_frame(8'h3C, 1'b0, 1'b0, 6'd32);
        build_model(8'h3C, 1'b0, 1'b0, 32);
        capture(exp_len - 1);
        e = diff_count();
        total++;
        if (e !== 0) begin
            bad++;
            $display("FAIL b2b_first: %0d bad cycles (first %0d)", e, first_bad);
        end
        total++;
        if (busy !== 1'b0 || tx_out !== 1'b1) begin
            bad++;
            $display("FAIL b2b_last_stop: busy=%b tx_out=%b, want 0/1",
                     busy, tx_out);
        end
        start_frame(8'h55, 1'b0, 1'b0, 6'd32);
        total++;
        if (tx_out !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_no_gap: tx_out=%b busy=%b, want 0/1",
                     tx_out, busy);
        end
        build_model(8'h55, 1'b0, 1'b0, 32);
        capture(exp_len + 1);
        e = diff_count();
        total++;
        if (e !== 0) begin
            bad++;
            $display("FAIL b2b_second: %0d bad cycles (first %0d)", e, first_bad);
        end
    endtask

    task automatic test_two_stop();
        int run;
        int bb;
        start_frame(8'h5A, 1'b0, 1'b0, 6'd8);
        build_model(8'h5A, 1'b0, 1'b0, 8);
        capture(exp_len + 1);
        run = 0;
        for (int k = 72; k < obs_tx.size(); k++) begin
            if (obs_busy[k] === 1'b0 && k > 72 && obs_busy[k-1] === 1'b0) break;
            if (obs_tx[k] === 1'b1) run++;
        end
        total++;
        if (run !== 8 * NSTOP) begin
            bad++;
            $display("FAIL stop_len: stop high %0d cycles, want %0d",
                     run, 8 * NSTOP);
        end
        bb = busy_high() + 1;
        total++;
        if (bb !== 72 + 8 * NSTOP) begin
            bad++;
            $display("FAIL stop_busy: busy=%0d, want %0d", bb, 72 + 8 * NSTOP);
        end
    endtask

    task automatic test_random();
        int plist[6] = '{8, 16, 32, 1, 5, 8};
        logic [7:0] d;
        logic pe;
        logic pt;
        int e;
        for (int i = 0; i < 6; i++) begin
            d  = 8'($urandom_range(0, 255));
            pe = 1'($urandom_range(0, 1));
            pt = 1'($urandom_range(0, 1));
            start_frame(d, pe, pt, 6'(plist[i]));
            build_model(d, pe, pt, plist[i]);
            capture(exp_len + 1);
            e = diff_count();
            total++;
            if (e !== 0) begin
                bad++;
                $display("FAIL random[%0d] d=%h pe=%b pt=%b p=%0d: %0d bad (first %0d)",
                         i, d, pe, pt, plist[i], e, first_bad);
            end
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b0;
        prescale   = 6'd8;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        data_in    = 8'h00;
        data_valid = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_parity();
        test_handshake();
        test_back_to_back();
        test_two_stop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
UART transmitter: serialises one parallel byte per frame onto tx_out. Frame format is start bit, 8 data bits LSB first, optional parity bit, stop bit.
Bit timing uses the same oversampling prescale convention as the receive path, so one bit lasts prescale clk cycles. An RX/TX pair configured with the same prescale, par_en and par_typ interoperates.
Sits between the host register interface and the serial pin.

Parameters:
DATA_W, 8, data bits per frame
PRESC_W, 6, width of prescale input (covers 8/16/32)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
prescale  input  PRESC_W  clk cycles per bit; legal 8, 16, 32
par_en  input  1  1 = parity bit inserted after data
par_typ  input  1  0 = even parity, 1 = odd parity
data_in  input  DATA_W  byte to transmit
data_valid  input  1  request; accepted when busy=0
busy  output  1  frame in progress, new requests ignored
tx_out  output  1  serial line, idles high

Behaviour:
- Reset (rst=1, asynchronous, any state including mid-frame):
  - tx_out=1, busy=0, state=IDLE, counters cleared.
- Acceptance: at a rising edge with data_valid=1 and busy=0, latch data_in, par_en, par_typ and prescale. Inputs changed after acceptance do not affect the frame.
- Request while busy=1: ignored, never queued.
- Latency: request accepted at edge N; busy=1 and tx_out=0 (start bit) from edge N+1.
- tx_out and busy are registered; no combinational path from inputs.
- FSM states and transitions:
  - IDLE: tx_out=1; goes to START on accept.
  - START: tx_out=0 for prescale cycles, then DATA.
  - DATA: bit index 0..DATA_W-1, LSB first, each bit held prescale cycles. After bit DATA_W-1 go to PARITY if par_en, else STOP.
  - PARITY: tx_out = XOR(data) XOR par_typ for prescale cycles, then STOP.
  - STOP: tx_out=1 for prescale cycles, then IDLE.
- Bit-cycle counter: counts 0..prescale-1. Bit boundary when counter = prescale-1; wraps to 0.
- Bit index: 3 bits, wraps only on the DATA exit.
- busy deasserts during the final clk of STOP. A request accepted in that cycle starts the next START immediately, giving back-to-back frames with no idle gap.
- Otherwise FSM returns to IDLE; tx_out stays 1.
- Frame length is (10 + par_en) * prescale cycles.
- Illegal prescale (not 8/16/32): bit period is still prescale cycles for prescale >= 2. Values 0 and 1 are treated as 2.

Optional Feature:
Macro UART_TX_TWO_STOP_EN.
- Defined: STOP lasts 2*prescale cycles (two stop bits). Frame length is (11 + par_en) * prescale. busy deasserts in the final clk of the second stop bit.
- Undefined: one stop bit exactly as above.

Test Plan:
- Reset: rst=1 mid-DATA of 0x3C frame -> tx_out=1 and busy=0 same cycle. After release, 0x00 sent next -> start bit seen 1 cycle after accept.
- Basic frame: prescale=8, par_en=0, data 0xA5 -> tx_out holds 0,1,0,1,0,0,1,0,1,1, each for exactly 8 cycles. busy high for 80 cycles.
- Parity: prescale=16, par_en=1, 0xA5 -> parity bit 0 with par_typ=0, 1 with par_typ=1. Frame is 176 cycles. Repeat for 0x07 -> even=1, odd=0.
- Handshake: data_valid held high with 0x11 then 0x22 during busy -> only 0x11 sent. data_in changed to 0xFF mid-frame -> transmitted bits unchanged.
- Back-to-back: prescale=32, data_valid pulsed in last stop cycle with 0x55 -> next start bit begins the following cycle, no idle cycle.
- Two-stop (UART_TX_TWO_STOP_EN): prescale=8, 0x5A -> stop high for 16 cycles, busy 88 cycles.
